avst_pkt_gen: RTL and testbench



---
 rtl/avst_pkt_gen_pkg.sv | 61 ++++++
 rtl/avst_pkt_gen_regs.sv | 127 ++++++++++++
 rtl/avst_pkt_gen.sv | 120 ++++++++++++
 tb/tb_avst_pkt_gen.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avst_pkt_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | avst_pkt_gen_pkg                                                           |
// | Register map, bit indices, FSM states and Avalon-MM/ST interfaces.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package avst_pkt_gen_pkg;

  localparam logic [7:0] c_ADDR_CTRL   = 8'h00;
  localparam logic [7:0] c_ADDR_STATUS = 8'h01;
  localparam logic [7:0] c_ADDR_LEN    = 8'h02;
  localparam logic [7:0] c_ADDR_SEED   = 8'h03;
  localparam logic [7:0] c_ADDR_COUNT  = 8'h04;
  localparam logic [7:0] c_ADDR_GAP    = 8'h05;
  localparam logic [7:0] c_ADDR_SENT   = 8'h06;

  localparam int c_CTRL_START = 0;
  localparam int c_CTRL_ABORT = 1;
  localparam int c_STAT_BUSY  = 0;
  localparam int c_STAT_DONE  = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

interface IAvalonMM #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
);
  logic [ADDRESS_WIDTH-1:0] address;
  logic                     read;
  logic                     write;
  logic [DATA_WIDTH-1:0]    writedata;
  logic [DATA_WIDTH-1:0]    readdata;
  logic                     waitrequest;

  modport Slave  (input address, read, write, writedata, output readdata, waitrequest);
  modport Master (output address, read, write, writedata, input readdata, waitrequest);
endinterface

interface IAvalonST #(
  parameter int DATA_WIDTH  = 32,
  parameter int ERROR_WIDTH = 1,
  parameter int EMPTY_WIDTH = 2
);
  logic [DATA_WIDTH-1:0]  data;
  logic                   valid;
  logic                   ready;
  logic                   sop;
  logic                   eop;
  logic [EMPTY_WIDTH-1:0] empty;
  logic [ERROR_WIDTH-1:0] error;

  modport Source (output data, valid, sop, eop, empty, error, input ready);
  modport Sink   (input data, valid, sop, eop, empty, error, output ready);
endinterface
`default_nettype wire

// File: rtl/avst_pkt_gen_regs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | avst_pkt_gen_regs                                                          |
// | Avalon-MM slave: register file, shadow latch, START/ABORT pulses.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module avst_pkt_gen_regs
  import avst_pkt_gen_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] i_address,
  input  logic                     i_read,
  input  logic                     i_write,
  input  logic [DATA_WIDTH-1:0]    i_writedata,
  output logic [DATA_WIDTH-1:0]    o_readdata,
  output logic                     o_waitrequest,
  input  logic                     i_busy,
  input  logic                     i_done_set,
  input  logic                     i_eop_xfer,
  output logic                     o_start,
  output logic                     o_abort,
  output logic [15:0]              o_len,
  output logic [DATA_WIDTH-1:0]    o_seed,
  output logic [15:0]              o_count,
  output logic [7:0]               o_gap
);

  logic [15:0]           r_len, r_count, r_sent;
  logic [DATA_WIDTH-1:0] r_seed;
  logic [7:0]            r_gap;
  logic [15:0]           r_len_sh, r_count_sh;
  logic [DATA_WIDTH-1:0] r_seed_sh;
  logic [7:0]            r_gap_sh;
  logic                  r_done, r_start, r_abort, r_rd_pend;
  logic [DATA_WIDTH-1:0] r_readdata;

  logic                  w_wr_ctrl, w_start, w_abort;
  logic [DATA_WIDTH-1:0] w_rdmux;

  assign w_wr_ctrl = i_write && (i_address == ADDRESS_WIDTH'(c_ADDR_CTRL));
  // r_start covers the one cycle before the FSM reports busy
  assign w_start   = w_wr_ctrl && i_writedata[c_CTRL_START] && !i_busy && !r_start;
  assign w_abort   = w_wr_ctrl && i_writedata[c_CTRL_ABORT] && i_busy;

  always_comb begin
    w_rdmux = '0;
    case (i_address)
      ADDRESS_WIDTH'(c_ADDR_STATUS): begin
        w_rdmux[c_STAT_BUSY] = i_busy;
        w_rdmux[c_STAT_DONE] = r_done;
      end
      ADDRESS_WIDTH'(c_ADDR_LEN):   w_rdmux = DATA_WIDTH'(r_len);
      ADDRESS_WIDTH'(c_ADDR_SEED):  w_rdmux = r_seed;
      ADDRESS_WIDTH'(c_ADDR_COUNT): w_rdmux = DATA_WIDTH'(r_count);
      ADDRESS_WIDTH'(c_ADDR_GAP):   w_rdmux = DATA_WIDTH'(r_gap);
      ADDRESS_WIDTH'(c_ADDR_SENT):  w_rdmux = DATA_WIDTH'(r_sent);
      default:                      w_rdmux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len      <= '0;
      r_seed     <= '0;
      r_count    <= '0;
      r_gap      <= '0;
      r_sent     <= '0;
      r_len_sh   <= '0;
      r_seed_sh  <= '0;
      r_count_sh <= '0;
      r_gap_sh   <= '0;
      r_done     <= 1'b0;
      r_start    <= 1'b0;
      r_abort    <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_readdata <= '0;
    end else begin
      r_start <= w_start;
      r_abort <= w_abort;

      if (i_write) begin
        case (i_address)
          ADDRESS_WIDTH'(c_ADDR_LEN):   r_len   <= i_writedata[15:0];
          ADDRESS_WIDTH'(c_ADDR_SEED):  r_seed  <= i_writedata;
          ADDRESS_WIDTH'(c_ADDR_COUNT): r_count <= i_writedata[15:0];
          ADDRESS_WIDTH'(c_ADDR_GAP):   r_gap   <= i_writedata[7:0];
          default: ;
        endcase
      end

      if (w_start) begin
        r_len_sh   <= r_len;
        r_seed_sh  <= r_seed;
        r_count_sh <= r_count;
        r_gap_sh   <= r_gap;
        r_done     <= 1'b0;
        r_sent     <= '0;
      end else begin
        if (i_done_set) r_done <= 1'b1;
        if (i_eop_xfer) r_sent <= r_sent + 16'd1;
      end

      // one wait state: capture on the first read cycle, present on the second
      if (i_read && !r_rd_pend) begin
        r_rd_pend  <= 1'b1;
        r_readdata <= w_rdmux;
      end else begin
        r_rd_pend  <= 1'b0;
      end
    end
  end

  assign o_waitrequest = i_read && !r_rd_pend && !rst;
  assign o_readdata    = r_readdata;
  assign o_start       = r_start;
  assign o_abort       = r_abort;
  assign o_len         = r_len_sh;
  assign o_seed        = r_seed_sh;
  assign o_count       = r_count_sh;
  assign o_gap         = r_gap_sh;

endmodule
`default_nettype wire

// File: rtl/avst_pkt_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | avst_pkt_gen                                                               |
// | Avalon-ST packet source of incrementing words, configured over Avalon-MM. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module avst_pkt_gen
  import avst_pkt_gen_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic     Clk_CI,
  input  logic     Rst_RI,
  IAvalonMM.Slave  Mm,
  IAvalonST.Source St
);

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_word;
  logic [15:0]           r_beat, r_left;
  logic [7:0]            r_gap_cnt;
  logic                  r_abort_pend;

  logic                  w_start, w_abort;
  logic [15:0]           w_len, w_count, w_len_m1;
  logic [DATA_WIDTH-1:0] w_seed;
  logic [7:0]            w_gap;
  logic                  w_valid, w_xfer, w_eop, w_eop_xfer, w_last, w_abort_any, w_done_set;

  avst_pkt_gen_regs #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_regs (
    .clk           (Clk_CI),
    .rst           (Rst_RI),
    .i_address     (Mm.address),
    .i_read        (Mm.read),
    .i_write       (Mm.write),
    .i_writedata   (Mm.writedata),
    .o_readdata    (Mm.readdata),
    .o_waitrequest (Mm.waitrequest),
    .i_busy        (r_state != ST_IDLE),
    .i_done_set    (w_done_set),
    .i_eop_xfer    (w_eop_xfer),
    .o_start       (w_start),
    .o_abort       (w_abort),
    .o_len         (w_len),
    .o_seed        (w_seed),
    .o_count       (w_count),
    .o_gap         (w_gap)
  );

  // LEN of 0 behaves as a single-beat packet
  assign w_len_m1    = (w_len == 16'd0) ? 16'd0 : w_len - 16'd1;
  assign w_valid     = (r_state == ST_SEND);
  assign w_xfer      = w_valid && St.ready;
  assign w_eop       = (r_beat == w_len_m1);
  assign w_eop_xfer  = w_xfer && w_eop;
  assign w_last      = (w_count != 16'd0) && (r_left == 16'd1);
  assign w_abort_any = r_abort_pend || w_abort;

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_SEND;
      ST_SEND: begin
        if (w_eop_xfer) begin
          if (w_last || w_abort_any) w_state_nxt = ST_IDLE;
          else if (w_gap != 8'd0)    w_state_nxt = ST_GAP;
          else                       w_state_nxt = ST_SEND;
        end
      end
      ST_GAP:  if (r_gap_cnt == 8'd0) w_state_nxt = w_abort_any ? ST_IDLE : ST_SEND;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_done_set = (r_state != ST_IDLE) && (w_state_nxt == ST_IDLE);

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      r_word       <= '0;
      r_beat       <= '0;
      r_left       <= '0;
      r_gap_cnt    <= '0;
      r_abort_pend <= 1'b0;
    end else if (r_state == ST_IDLE && w_start) begin
      r_word       <= w_seed;
      r_beat       <= '0;
      r_left       <= w_count;
      r_abort_pend <= 1'b0;
    end else begin
      if (w_abort) r_abort_pend <= 1'b1;
      if (w_xfer) begin
        r_word <= r_word + DATA_WIDTH'(1);
        r_beat <= w_eop ? 16'd0 : r_beat + 16'd1;
      end
      if (w_eop_xfer && w_count != 16'd0) r_left <= r_left - 16'd1;
      if (w_eop_xfer)
        r_gap_cnt <= w_gap - 8'd1;
      else if (r_state == ST_GAP && r_gap_cnt != 8'd0)
        r_gap_cnt <= r_gap_cnt - 8'd1;
    end
  end

  assign St.valid = w_valid;
  assign St.data  = r_word;
  assign St.sop   = w_valid && (r_beat == 16'd0);
  assign St.eop   = w_valid && w_eop;
  assign St.empty = '0;
  assign St.error = '0;

endmodule
`default_nettype wire

// File: tb/tb_avst_pkt_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_avst_pkt_gen                                                            |
// | Directed bench with a beat-queue model checked on every cycle.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_avst_pkt_gen;

  localparam logic [7:0] A_CTRL = 8'h00, A_STATUS = 8'h01, A_LEN = 8'h02, A_SEED = 8'h03;
  localparam logic [7:0] A_COUNT = 8'h04, A_GAP = 8'h05, A_SENT = 8'h06, A_NONE = 8'h07;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  logic  clk;
  logic  rst;
  int    n_vec = 0;
  int    n_err = 0;
  int    exp_gap;
  beat_t exp_q[$];

  IAvalonMM #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32)) mm ();
  IAvalonST #(.DATA_WIDTH(32), .ERROR_WIDTH(1)) st ();

  avst_pkt_gen #(.DATA_WIDTH(32), .ADDRESS_WIDTH(8)) dut (
    .Clk_CI (clk),
    .Rst_RI (rst),
    .Mm     (mm),
    .St     (st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected beat stream: words run on from SEED across packets
  function automatic void push_run(input int len, input logic [31:0] seed, input int count);
    int          l = (len == 0) ? 1 : len;
    logic [31:0] w = seed;
    beat_t       nb;
    for (int p = 0; p < count; p++) begin
      for (int b = 0; b < l; b++) begin
        nb.data = w;
        nb.sop  = (b == 0);
        nb.eop  = (b == l - 1);
        exp_q.push_back(nb);
        w = w + 32'd1;
      end
    end
  endfunction

  task automatic mm_write(input logic [7:0] a, input logic [31:0] d);
    mm.address   = a;
    mm.writedata = d;
    mm.write     = 1'b1;
    @(negedge clk);
    chk("wr_waitrequest", {31'd0, mm.waitrequest}, 32'd0);
    tick();
    mm.write = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
    mm.address = a;
    mm.read    = 1'b1;
    @(negedge clk);
    chk("rd_wait_first", {31'd0, mm.waitrequest}, 32'd1);
    tick();
    @(negedge clk);
    chk("rd_wait_second", {31'd0, mm.waitrequest}, 32'd0);
    chk(name, mm.readdata, exp);
    tick();
    mm.read = 1'b0;
  endtask

  task automatic cfg(input int len, input logic [31:0] seed, input int count, input int gap);
    mm_write(A_LEN, 32'(len));
    mm_write(A_SEED, seed);
    mm_write(A_COUNT, 32'(count));
    mm_write(A_GAP, 32'(gap));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk("drain_remaining", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_beat(input string name, input logic [31:0] d, input logic s, input logic e);
    @(negedge clk);
    chk({name, "_valid"}, {31'd0, st.valid}, 32'd1);
    chk({name, "_data"}, st.data, d);
    chk({name, "_sop"}, {31'd0, st.sop}, {31'd0, s});
    chk({name, "_eop"}, {31'd0, st.eop}, {31'd0, e});
  endtask

  // Per-cycle compare against the beat queue
  logic  need_valid = 1'b0;
  logic  waiting    = 1'b0;
  int    idle       = 0;
  beat_t cur;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      need_valid = 1'b0;
      waiting    = 1'b0;
      idle       = 0;
    end else begin
      if (need_valid) chk("valid_held", {31'd0, st.valid}, 32'd1);
      need_valid = 1'b0;
      if (waiting) begin
        if (!st.valid) idle++;
        else begin
          chk("gap_cycles", 32'(idle), 32'(exp_gap));
          waiting = 1'b0;
        end
      end
      if (exp_q.size() == 0) begin
        chk("no_beat_expected", {31'd0, st.valid}, 32'd0);
      end else if (st.valid) begin
        cur = exp_q[0];
        chk("beat_data", st.data, cur.data);
        chk("beat_sop", {31'd0, st.sop}, {31'd0, cur.sop});
        chk("beat_eop", {31'd0, st.eop}, {31'd0, cur.eop});
        chk("beat_empty_error", {29'd0, st.empty, st.error}, 32'd0);
        if (st.ready) begin
          void'(exp_q.pop_front());
          if (cur.eop) begin
            if (exp_q.size() != 0) begin
              waiting = 1'b1;
              idle    = 0;
            end
          end else begin
            need_valid = 1'b1;
          end
        end else begin
          need_valid = 1'b1;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    mm.address   = '0;
    mm.read      = 1'b0;
    mm.write     = 1'b0;
    mm.writedata = '0;
    st.ready     = 1'b1;
    exp_gap      = 0;
    repeat (3) tick();
    rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_valid", {31'd0, st.valid}, 32'd0);
    chk("rst_sop_eop", {30'd0, st.sop, st.eop}, 32'd0);
    chk("rst_data", st.data, 32'd0);
    chk("rst_readdata", mm.readdata, 32'd0);
    chk("rst_waitrequest", {31'd0, mm.waitrequest}, 32'd0);
    tick();
    rd_chk("rst_status", A_STATUS, 32'd0);
    rd_chk("rst_len", A_LEN, 32'd0);
    rd_chk("rst_sent", A_SENT, 32'd0);
    mm_write(A_NONE, 32'hABCD1234);
    rd_chk("unmapped_read", A_NONE, 32'd0);
    rd_chk("ctrl_read", A_CTRL, 32'd0);

    // two back-to-back packets of 4
    cfg(4, 32'h10, 2, 0);
    exp_gap = 0;
    push_run(4, 32'h10, 2);
    mm_write(A_CTRL, 32'h1);
    tick();
    chk_beat("t1_first", 32'h10, 1'b1, 1'b0);
    wait_drain();
    repeat (3) tick();
    rd_chk("t1_sent", A_SENT, 32'd2);
    rd_chk("t1_status", A_STATUS, 32'd2);

    // gap of 5; mid-run LEN write and START must not disturb the run
    cfg(3, 32'h200, 2, 5);
    exp_gap = 5;
    push_run(3, 32'h200, 2);
    mm_write(A_CTRL, 32'h1);
    tick();
    tick();
    mm_write(A_LEN, 32'd9);
    mm_write(A_CTRL, 32'h1);
    wait_drain();
    repeat (3) tick();
    rd_chk("t2_sent", A_SENT, 32'd2);
    rd_chk("t2_len_visible", A_LEN, 32'd9);

    // ready pattern 1,0,0,1 inside a packet
    cfg(6, 32'h100, 1, 0);
    exp_gap = 0;
    push_run(6, 32'h100, 1);
    mm_write(A_CTRL, 32'h1);
    tick();
    tick();
    st.ready = 1'b0;
    tick();
    chk_beat("t3_stall", 32'h101, 1'b0, 1'b0);
    tick();
    st.ready = 1'b1;
    wait_drain();
    repeat (3) tick();

    // endless run aborted mid packet
    cfg(8, 32'h1000, 0, 0);
    push_run(8, 32'h1000, 1);
    mm_write(A_CTRL, 32'h1);
    repeat (3) tick();
    mm_write(A_CTRL, 32'h2);
    wait_drain();
    repeat (12) tick();
    rd_chk("t4_status", A_STATUS, 32'd2);
    rd_chk("t4_sent", A_SENT, 32'd1);

    // LEN 0 single-beat packets with data wrap
    cfg(0, 32'hFFFF_FFFF, 2, 0);
    push_run(0, 32'hFFFF_FFFF, 2);
    mm_write(A_CTRL, 32'h1);
    tick();
    chk_beat("t5_beat0", 32'hFFFF_FFFF, 1'b1, 1'b1);
    tick();
    chk_beat("t5_beat1", 32'h0, 1'b1, 1'b1);
    wait_drain();
    repeat (3) tick();
    rd_chk("t5_sent", A_SENT, 32'd2);

    // reset during beat 2 of 4
    cfg(4, 32'h40, 1, 0);
    push_run(4, 32'h40, 1);
    mm_write(A_CTRL, 32'h1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_valid_after_rst", {31'd0, st.valid}, 32'd0);
    chk("t6_eop_after_rst", {31'd0, st.eop}, 32'd0);
    tick();
    rd_chk("t6_len", A_LEN, 32'd0);
    rd_chk("t6_seed", A_SEED, 32'd0);
    rd_chk("t6_count", A_COUNT, 32'd0);
    rd_chk("t6_gap", A_GAP, 32'd0);
    rd_chk("t6_sent", A_SENT, 32'd0);
    rd_chk("t6_status", A_STATUS, 32'd0);
    cfg(2, 32'h55, 1, 0);
    push_run(2, 32'h55, 1);
    mm_write(A_CTRL, 32'h1);
    tick();
    chk_beat("t6_restart", 32'h55, 1'b1, 1'b0);
    wait_drain();
    repeat (3) tick();
    rd_chk("t6_done", A_STATUS, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
